cozy_lsu: RTL and testbench
===========================

// Module: cozy_lsu
// PURPOSE
//  Load/store unit for the cozy core. Sits downstream of the register file read ports and upstream of its write port.
//  Takes the base (rS) and store data (rD) operands, forms a byte address, and runs 1-2 external bus transactions.
//  For loads, writes the result back through rD_sel/rD_we/rD_in. Unaligned word accesses are split into two byte accesses.
// PARAMETERS
//  TIMEOUT  255  max cycles mem_req may wait for mem_ack; 0 = never time out
//  TO_W     8    width of timeout counter (must hold TIMEOUT)
// PORTS
//  clk        in   1   system clock, all state on posedge
//  rst_n      in   1   asynchronous, active-low reset
//  start      in   1   issue op; accepted only when busy=0
//  is_store   in   1   1=store, 0=load
//  is_byte    in   1   1=byte access, 0=16-bit word
//  ld_signed  in   1   byte loads: 1=sign-extend, 0=zero-extend
//  offset     in   8   signed displacement added to base
//  base       in   16  rS operand (regfile rS_out)
//  sdata      in   16  store data (regfile rD_out)
//  dst_sel    in   4   destination register for loads
//  busy       out  1   op in flight
//  done       out  1   1-cycle pulse: op completed OK
//  err        out  1   1-cycle pulse: op aborted by timeout
//  rD_sel     out  4   regfile write select
//  rD_we      out  1   regfile write enable
//  rD_in      out  16  regfile write data
//  mem_req    out  1   bus request, held until ack
//  mem_we     out  1   bus write
//  mem_addr   out  15  word address (byte address [15:1])
//  mem_be     out  2   byte enables; be[0]=bits[7:0]=even byte
//  mem_wdata  out  16  write data, lane-aligned
//  mem_ack    in   1   bus accept/complete, sampled on clk while mem_req=1
//  mem_rdata  in   16  read data, valid with mem_ack
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; latched op fields cleared. Reset mid-op aborts immediately: no writeback, no done.
//  EA = base + sext(offset), modulo 2^16. Little-endian: even byte in lane 0.
//  States: IDLE -> ACC0 -> [ACC1] -> WB -> IDLE.
//   IDLE: busy=0. On start, latch all inputs and EA, go to ACC0. start while busy=1 is ignored, not queued.
//   ACC0: mem_req=1, addr/be/we/wdata stable until ack.
//    Word, EA[0]=0: addr=EA[15:1], be=11.
//    Byte: be=01 if EA[0]=0, else 10; store byte replicated on both lanes.
//    Word, EA[0]=1: first beat is low byte at addr EA[15:1], be=10.
//    On ack: go to ACC1 if split, else WB.
//   ACC1 (split only): high byte at addr EA[15:1]+1 (wraps 7FFF->0000), be=01.
//   WB: one cycle. done=1. For loads also rD_we=1, rD_sel=dst_sel, rD_in=result. Then IDLE.
//    rD_sel=0 loads still assert rD_we; the regfile discards the write.
//  Latency: start at cycle N, mem_req rises N+1. Ack in the same cycle gives WB/done at N+2; a split access adds >=1 cycle.
//  Load data: read beat bytes are captured at ack into a 16-bit assembly register.
//   Byte result extended per ld_signed; unused be lanes ignored.
//  Timeout: counter resets on entry to ACC0/ACC1 and increments each cycle req=1 without ack.
//   On reaching TIMEOUT: drop mem_req, err=1 for 1 cycle, no rD_we, no done, return to IDLE.
//   A split op that times out in ACC1 has already written its first beat to memory.
//  mem_req deasserts in the cycle after ack; back-to-back requests are never issued without one idle cycle between them.
//  rD_we is asserted only in WB.
// STRUCTURE
//  cozy_pkg: state encodings (IDLE/ACC0/ACC1/WB), BE_LO/BE_HI/BE_W constants.
//  Sub-module cozy_lsu_lane: combinational lane logic.
//   Store side: wdata/be generation from EA[0], is_byte, split beat.
//   Load side: byte extract/extend and merge.
//  Top level holds FSM, timeout counter, assembly register.
// TESTING
//  Aligned word load: base=0x1000, off=+4, mem_rdata=0xBEEF, immediate ack
//   -> addr=0x0802, be=11; rD_we=1, rD_in=0xBEEF at N+2; done=1.
//  Signed byte load: EA=0x2001, rdata=0x80xx, ld_signed=1 -> be=10, rD_in=0xFF80; with ld_signed=0 -> 0x0080.
//  Unaligned word store: EA=0x0003, sdata=0xA1B2
//   -> beat1 addr=0x0001, be=10, wdata[15:8]=0xB2; beat2 addr=0x0002, be=01, wdata[7:0]=0xA1; no rD_we.
//  Wrap: base=0xFFFF, off=0, unaligned word load -> beat2 addr=0x0000; rD_in={beat2 lane0, beat1 lane1}.
//  Timeout: TIMEOUT=4, ack never -> err pulse 4 cycles after req rose; req drops; no rD_we; busy=0; next start accepted.
//  Robustness: start pulsed during busy -> ignored. rst_n low mid-ACC0 -> req=0 immediately; no done or writeback.

Source files
------------

// File: rtl/cozy_pkg.sv
// Shared definitions for the cozy load/store unit: FSM states, byte-enable
// codes and effective-address arithmetic.
package cozy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_WB   = 2'd3
  } lsu_state_t;

  localparam logic [1:0] BE_LO = 2'b01;
  localparam logic [1:0] BE_HI = 2'b10;
  localparam logic [1:0] BE_W  = 2'b11;

  // Byte address = base + sign-extended displacement, wrapping at 64 KiB.
  function automatic logic [15:0] calc_ea(input logic [15:0] base, input logic [7:0] off);
    return base + {{8{off[7]}}, off};
  endfunction

endpackage

// File: rtl/cozy_lsu_lane.sv
// Combinational lane steering for the LSU.
// Store side: write data and byte enables for a beat. Load side: byte merge and extension.
module cozy_lsu_lane
  import cozy_pkg::*;
(
  input  logic        st_ea0,
  input  logic        st_byte,
  input  logic        st_beat2,
  input  logic [15:0] st_data,
  output logic [1:0]  st_be,
  output logic [15:0] st_wdata,
  input  logic        ld_ea0,
  input  logic        ld_byte,
  input  logic        ld_beat2,
  input  logic        ld_signed,
  input  logic [15:0] ld_asm,
  input  logic [15:0] ld_rdata,
  output logic [15:0] ld_asm_next,
  output logic [15:0] ld_result
);

  // Store beat: bytes are replicated on both lanes, so only the enable selects the target.
  always_comb begin
    st_be    = BE_W;
    st_wdata = st_data;
    if (st_byte) begin
      st_be    = st_ea0 ? BE_HI : BE_LO;
      st_wdata = {st_data[7:0], st_data[7:0]};
    end else if (st_ea0 && !st_beat2) begin
      st_be    = BE_HI;
      st_wdata = {st_data[7:0], st_data[7:0]};
    end else if (st_ea0 && st_beat2) begin
      st_be    = BE_LO;
      st_wdata = {st_data[15:8], st_data[15:8]};
    end else begin
      st_be    = BE_W;
      st_wdata = st_data;
    end
  end

  // Load beat: pull the enabled lane into its place in the assembly word.
  always_comb begin
    ld_asm_next = ld_rdata;
    ld_result   = ld_rdata;
    if (ld_byte) begin
      ld_asm_next = {8'h00, (ld_ea0 ? ld_rdata[15:8] : ld_rdata[7:0])};
    end else if (!ld_ea0) begin
      ld_asm_next = ld_rdata;
    end else if (ld_beat2) begin
      ld_asm_next = {ld_rdata[7:0], ld_asm[7:0]};
    end else begin
      ld_asm_next = {ld_asm[15:8], ld_rdata[15:8]};
    end
    if (ld_byte) begin
      ld_result = {{8{ld_signed & ld_asm_next[7]}}, ld_asm_next[7:0]};
    end else begin
      ld_result = ld_asm_next;
    end
  end

endmodule

// File: rtl/cozy_lsu.sv
// Load/store unit: latches an op, runs one or two bus beats (unaligned words
// split into two byte beats) and writes load results back to the regfile.
module cozy_lsu
  import cozy_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic        is_byte,
  input  logic        ld_signed,
  input  logic [7:0]  offset,
  input  logic [15:0] base,
  input  logic [15:0] sdata,
  input  logic [3:0]  dst_sel,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [3:0]  rD_sel,
  output logic        rD_we,
  output logic [15:0] rD_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam bit              TO_EN   = (TIMEOUT != 0);

  lsu_state_t      r_state;
  logic [15:0]     r_ea;
  logic            r_is_store;
  logic            r_is_byte;
  logic            r_signed;
  logic [15:0]     r_sdata;
  logic [3:0]      r_dst;
  logic [15:0]     r_asm;
  logic [TO_W-1:0] r_cnt;

  logic [15:0] w_ea;
  logic        w_idle;
  logic        w_split;
  logic [1:0]  w_be;
  logic [15:0] w_wdata;
  logic [15:0] w_asm_next;
  logic [15:0] w_ld_result;

  assign w_ea    = calc_ea(base, offset);
  assign w_idle  = (r_state == ST_IDLE);
  assign w_split = !r_is_byte && r_ea[0];

  // In IDLE the store lane sees the incoming op (first beat); afterwards it prepares beat two.
  cozy_lsu_lane u_lane (
    .st_ea0      (w_idle ? w_ea[0] : r_ea[0]),
    .st_byte     (w_idle ? is_byte : r_is_byte),
    .st_beat2    (!w_idle),
    .st_data     (w_idle ? sdata : r_sdata),
    .st_be       (w_be),
    .st_wdata    (w_wdata),
    .ld_ea0      (r_ea[0]),
    .ld_byte     (r_is_byte),
    .ld_beat2    (r_state == ST_ACC1),
    .ld_signed   (r_signed),
    .ld_asm      (r_asm),
    .ld_rdata    (mem_rdata),
    .ld_asm_next (w_asm_next),
    .ld_result   (w_ld_result)
  );

  // Op sequencer, timeout counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ea       <= 16'h0000;
      r_is_store <= 1'b0;
      r_is_byte  <= 1'b0;
      r_signed   <= 1'b0;
      r_sdata    <= 16'h0000;
      r_dst      <= 4'h0;
      r_asm      <= 16'h0000;
      r_cnt      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      rD_sel     <= 4'h0;
      rD_we      <= 1'b0;
      rD_in      <= 16'h0000;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 15'h0000;
      mem_be     <= 2'b00;
      mem_wdata  <= 16'h0000;
    end else begin
      done   <= 1'b0;
      err    <= 1'b0;
      rD_we  <= 1'b0;
      rD_sel <= 4'h0;
      rD_in  <= 16'h0000;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_ACC0;
            r_ea       <= w_ea;
            r_is_store <= is_store;
            r_is_byte  <= is_byte;
            r_signed   <= ld_signed;
            r_sdata    <= sdata;
            r_dst      <= dst_sel;
            r_asm      <= 16'h0000;
            r_cnt      <= '0;
            busy       <= 1'b1;
            mem_req    <= 1'b1;
            mem_we     <= is_store;
            mem_addr   <= w_ea[15:1];
            mem_be     <= w_be;
            mem_wdata  <= w_wdata;
          end
        end
        ST_ACC0, ST_ACC1: begin
          if (!mem_req) begin
            // Idle gap between the two beats of a split access.
            mem_req <= 1'b1;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            r_asm   <= w_asm_next;
            r_cnt   <= '0;
            if ((r_state == ST_ACC0) && w_split) begin
              r_state   <= ST_ACC1;
              mem_addr  <= r_ea[15:1] + 15'd1;
              mem_be    <= w_be;
              mem_wdata <= w_wdata;
            end else begin
              r_state <= ST_WB;
              done    <= 1'b1;
              if (!r_is_store) begin
                rD_we  <= 1'b1;
                rD_sel <= r_dst;
                rD_in  <= w_ld_result;
              end
            end
          end else if (TO_EN && (r_cnt == TO_LAST)) begin
            r_state <= ST_IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + {{(TO_W-1){1'b0}}, 1'b1};
          end
        end
        ST_WB: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          mem_we  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cozy_lsu.sv
// Self-checking bench for cozy_lsu: byte-addressed memory responder with random
// ack delays and a byte-level reference model of every load/store.
module tb_cozy_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, is_store = 1'b0, is_byte = 1'b0, ld_signed = 1'b0;
  logic [7:0]  offset = 8'h00;
  logic [15:0] base = 16'h0000, sdata = 16'h0000;
  logic [3:0]  dst_sel = 4'h0;
  logic        busy, done, err, rD_we, mem_req, mem_we;
  logic [3:0]  rD_sel;
  logic [15:0] rD_in, mem_wdata;
  logic [14:0] mem_addr;
  logic [1:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;

  cozy_lsu #(.TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .is_byte(is_byte),
    .ld_signed(ld_signed), .offset(offset), .base(base), .sdata(sdata), .dst_sel(dst_sel),
    .busy(busy), .done(done), .err(err), .rD_sel(rD_sel), .rD_we(rD_we), .rD_in(rD_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:65535];
  int          n_checks = 0, n_fail = 0;
  int          cyc = 0;
  int          delays [2];
  logic        no_ack = 1'b0;
  logic [14:0] q_addr [$];
  logic [1:0]  q_be [$];
  logic        q_we [$];
  int          wait_cnt = 0, gap_viol = 0, stab_viol = 0;
  logic        prev_acked = 1'b0;
  logic [33:0] snap;
  int          n_done = 0, n_err = 0, n_we = 0, done_cyc = 0, err_cyc = 0;
  logic [3:0]  last_sel;
  logic [15:0] last_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: acks after the programmed delay, applies writes by byte enable.
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ack = 1'b0; wait_cnt = 0; prev_acked = 1'b0;
    end else if (mem_req) begin
      if (prev_acked) gap_viol++;
      if (wait_cnt == 0) snap = {mem_we, mem_addr, mem_be, mem_wdata};
      else if (snap !== {mem_we, mem_addr, mem_be, mem_wdata}) stab_viol++;
      if (!no_ack && wait_cnt >= delays[(q_addr.size() > 1) ? 1 : q_addr.size()]) begin
        mem_ack = 1'b1;
        mem_rdata = {mem[{mem_addr, 1'b1}], mem[{mem_addr, 1'b0}]};
        if (mem_we && mem_be[0]) mem[{mem_addr, 1'b0}] = mem_wdata[7:0];
        if (mem_we && mem_be[1]) mem[{mem_addr, 1'b1}] = mem_wdata[15:8];
        q_addr.push_back(mem_addr); q_be.push_back(mem_be); q_we.push_back(mem_we);
        wait_cnt = 0;
      end else begin
        mem_ack = 1'b0;
        mem_rdata = 16'($urandom);
        wait_cnt++;
      end
    end else begin
      mem_ack = 1'b0; wait_cnt = 0;
    end
    prev_acked = mem_ack;
  end

  // Output monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin n_done++; done_cyc = cyc; end
      if (err) begin n_err++; err_cyc = cyc; end
      if (rD_we) begin n_we++; last_sel = rD_sel; last_in = rD_in; end
    end
  end

  task automatic clear_obs();
    q_addr.delete(); q_be.delete(); q_we.delete();
    n_done = 0; n_err = 0; n_we = 0; gap_viol = 0; stab_viol = 0;
  endtask

  task automatic issue(input logic st, input logic byt, input logic sgn, input logic [7:0] off,
                       input logic [15:0] bs, input logic [15:0] sd, input logic [3:0] dst, output int s);
    @(negedge clk);
    is_store = st; is_byte = byt; ld_signed = sgn; offset = off; base = bs; sdata = sd; dst_sel = dst;
    start = 1'b1;
    @(posedge clk); #1;
    s = cyc; start = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic st, input logic byt, input logic sgn,
                       input logic [7:0] off, input logic [15:0] bs, input logic [15:0] sd,
                       input logic [3:0] dst, input int d0, input int d1, input logic inject);
    logic [15:0] ea, ea1, exp_ld;
    logic        split;
    int          nb, s, lat;
    ea = bs + {{8{off[7]}}, off};
    ea1 = ea + 16'd1;
    split = !byt && ea[0];
    nb = split ? 2 : 1;
    if (byt) exp_ld = {{8{sgn & mem[ea][7]}}, mem[ea]};
    else     exp_ld = {mem[ea1], mem[ea]};
    clear_obs(); delays[0] = d0; delays[1] = d1; no_ack = 1'b0;
    issue(st, byt, sgn, off, bs, sd, dst, s);
    chk({tag, "_busy"}, busy, 1);
    if (inject) begin
      @(negedge clk);
      is_store = ~st; offset = off + 8'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 64 && (n_done + n_err) == 0; i++) begin @(negedge clk); #1; end
    lat = done_cyc - s;
    repeat (3) @(negedge clk);
    #1;
    chk({tag, "_done"}, n_done, 1);
    chk({tag, "_err"}, n_err, 0);
    chk({tag, "_beats"}, q_addr.size(), nb);
    if (split) chk({tag, "_lat_split"}, (lat >= 3 + d0 + d1) && (lat <= 8 + d0 + d1), 1);
    else       chk({tag, "_lat"}, lat, 1 + d0);
    if (q_addr.size() >= 1) begin
      chk({tag, "_addr0"}, q_addr[0], ea[15:1]);
      chk({tag, "_be0"}, q_be[0], byt ? (ea[0] ? 2'b10 : 2'b01) : (ea[0] ? 2'b10 : 2'b11));
      chk({tag, "_we0"}, q_we[0], st);
    end
    if (split && q_addr.size() >= 2) begin
      chk({tag, "_addr1"}, q_addr[1], ea1[15:1]);
      chk({tag, "_be1"}, q_be[1], 2'b01);
      chk({tag, "_we1"}, q_we[1], st);
    end
    chk({tag, "_gap"}, gap_viol, 0);
    chk({tag, "_stable"}, stab_viol, 0);
    chk({tag, "_idle"}, busy, 0);
    if (st) begin
      chk({tag, "_nowe"}, n_we, 0);
      chk({tag, "_mem0"}, mem[ea], sd[7:0]);
      if (!byt) chk({tag, "_mem1"}, mem[ea1], sd[15:8]);
    end else begin
      chk({tag, "_we"}, n_we, 1);
      chk({tag, "_sel"}, last_sel, dst);
      chk({tag, "_data"}, last_in, exp_ld);
    end
  endtask

  initial begin
    int s;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    delays[0] = 0; delays[1] = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_outs", {done, err, rD_we, rD_sel, rD_in, mem_we, mem_addr, mem_be, mem_wdata}, 0);
    rst_n = 1'b1;

    mem[16'h1004] = 8'hEF; mem[16'h1005] = 8'hBE;
    do_op("ld_word", 0, 0, 0, 8'h04, 16'h1000, 16'h0000, 4'h3, 0, 0, 0);
    chk("ld_word_val", last_in, 16'hBEEF);
    mem[16'h2001] = 8'h80;
    do_op("ld_sb", 0, 1, 1, 8'h01, 16'h2000, 16'h0000, 4'h5, 0, 0, 0);
    chk("ld_sb_val", last_in, 16'hFF80);
    do_op("ld_ub", 0, 1, 0, 8'h01, 16'h2000, 16'h0000, 4'h6, 0, 0, 0);
    chk("ld_ub_val", last_in, 16'h0080);
    do_op("st_unal", 1, 0, 0, 8'h03, 16'h0000, 16'hA1B2, 4'h1, 0, 0, 0);
    chk("st_unal_b0", mem[16'h0003], 8'hB2);
    chk("st_unal_b1", mem[16'h0004], 8'hA1);
    mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h12;
    do_op("wrap", 0, 0, 0, 8'h00, 16'hFFFF, 16'h0000, 4'h0, 1, 2, 0);
    chk("wrap_val", last_in, 16'h1234);
    do_op("inject", 0, 0, 0, 8'h10, 16'h4000, 16'h0000, 4'h9, 0, 0, 1);

    // Timeout: no ack ever.
    clear_obs(); no_ack = 1'b1;
    issue(0, 0, 0, 8'h00, 16'h3000, 16'h0000, 4'h2, s);
    for (int i = 0; i < 64 && n_err == 0; i++) begin @(negedge clk); #1; end
    chk("to_err", n_err, 1);
    chk("to_lat", err_cyc - s, 4);
    chk("to_req", mem_req, 0);
    chk("to_busy", busy, 0);
    repeat (2) @(negedge clk);
    chk("to_done", n_done, 0);
    chk("to_we", n_we, 0);
    chk("to_errpulse", n_err, 1);
    do_op("after_to", 0, 0, 0, 8'h02, 16'h3000, 16'h0000, 4'h4, 0, 0, 0);

    // Reset in the middle of the first beat.
    clear_obs(); no_ack = 1'b1;
    issue(0, 0, 0, 8'h00, 16'h5000, 16'h0000, 4'h7, s);
    @(negedge clk);
    chk("mid_req", mem_req, 1);
    rst_n = 1'b0; #1;
    chk("rst_mid_req", mem_req, 0);
    chk("rst_mid_busy", busy, 0);
    @(negedge clk); rst_n = 1'b1; no_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_done", n_done, 0);
    chk("rst_mid_we", n_we, 0);
    chk("rst_mid_idle", mem_req, 0);
    do_op("after_rst", 0, 0, 1, 8'h01, 16'h5000, 16'h0000, 4'h8, 0, 0, 0);

    for (int k = 0; k < 40; k++) begin
      do_op("rnd", 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 16'($urandom),
            16'($urandom), 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
